wb_port_arbiter: RTL and testbench
==================================

# wb_port_arbiter

Shares the single register-file write port between two writeback sources (source 0: ALU result, source 1: load data) and drives the select line of the 32-bit 2:1 writeback data mux. Each source has a one-entry holding register behind a valid/ready handshake. The arbiter grants one entry per cycle using round-robin priority, with an ordering override for writes to the same register, and produces registered write-enable, address and data for the register file.

## Interface
- DATA_W, 32, width of write data (matches the 32-bit mux)
- ADDR_W, 4, register address width (r0–r15)

- clk  input  1  rising-edge clock
- reset  input  1  synchronous, active-high reset
- flush  input  1  pipeline flush; discards all held and in-flight writes
- req0_valid  input  1  source 0 presents a write
- req0_addr  input  ADDR_W  source 0 destination register
- req0_data  input  DATA_W  source 0 write data
- req0_ready  output  1  source 0 entry can accept this cycle
- req1_valid / req1_addr / req1_data / req1_ready  same as source 0, for source 1
- mux_select  output  1  select for the writeback mux; 0 = source 0 (in_data1), 1 = source 1 (in_data2)
- wr_en  output  1  register-file write enable
- wr_addr  output  ADDR_W  register-file write address
- wr_data  output  DATA_W  register-file write data, taken from the granted entry

## Operation
- Per-source state: full flag, addr, data, age stamp. An entry is accepted when valid && ready at a clock edge.
- Age: 1-bit "older" tracker. Between two full entries, the older is the one captured first. If both are captured on the same edge, entry 0 is older.
- Grant, combinational from registered state only:
  - Neither entry full: no grant.
  - One entry full: grant that entry.
  - Both full, addr0 == addr1: grant the older entry. This preserves program order to the same register.
  - Both full, addresses differ: grant the entry != rr_last.
- rr_last updates to the granted index on every grant.
- reqN_ready = !fullN || grantN. There is no combinational path from valid to ready. A granted entry can be refilled on the same edge it drains.
- On each edge with a grant:
  - wr_en = 1
  - wr_addr and wr_data take the granted entry's values
  - mux_select = granted index
  - the granted entry clears unless it is refilled on that edge
- On each edge without a grant: wr_en = 0; wr_addr, wr_data and mux_select hold their previous values.
- flush, synchronous, takes priority over everything except reset:
  - both full flags and wr_en clear on the next edge
  - requests presented in the flush cycle are dropped
  - ready outputs are 1 after the flush edge
- Reset values:
  - full0 = full1 = 0, so req0_ready = req1_ready = 1
  - wr_en = 0, wr_addr = 0, wr_data = 0
  - mux_select = 0
  - rr_last = 1, so source 0 wins the first contention
  - age tracker = 0
- Reset mid-operation drops held entries with no write issued.

## Timing
- Latency: request accepted at edge N → wr_en high in cycle N+1 → register-file write at edge N+2 when uncontended.
- Throughput: one write per cycle total. A lone source sustains one write per cycle with ready held at 1.
- Under continuous contention with different addresses, grants alternate 0,1,0,1…. Each source receives at least one grant in every 2 cycles, so there is no starvation.
- Same-address contention: the older write reaches wr_en exactly one cycle before the younger.
- Simultaneous accept on both sources: source 0 is written first when addresses match. Otherwise the round-robin decides.
- Back-pressure: ready drops only when the entry is full and not granted. A held request must keep valid, addr and data stable until accepted.

## Test plan
- Reset, then an idle cycle → wr_en=0, req0_ready=req1_ready=1, mux_select=0.
- A single req0 (addr 3, data 0xDEADBEEF) at edge 1 → wr_en=1, wr_addr=3, wr_data=0xDEADBEEF, mux_select=0 in cycle 2; wr_en=0 in cycle 3.
- Both sources valid every cycle for 8 cycles, addrs 1 and 2 → writes alternate src0,src1,… starting with src0; each ready toggles low/high; no write is lost or duplicated; scoreboard order matches.
- req1 (r5, 0x11) accepted one cycle before req0 (r5, 0x22), both pending → r5 written with 0x11, then 0x22; final value 0x22. Repeat with both accepted on the same edge → 0x22 first from source 0, then 0x11.
- Both entries full, flush asserted → wr_en=0 on the next cycle, no writes for held entries, both readys 1. A new req1 after flush is written with mux_select=1.
- Reset asserted while an entry is full and a wr_en pulse is due → wr_en=0 after the reset edge and the held write is never issued.

Source files
------------

// File: rtl/wb_port_arbiter.sv
// wb_port_arbiter
//
// Shares the single register-file write port between two writeback sources
// (source 0: ALU result, source 1: load data). Each source feeds a one-entry
// holding register through a valid/ready handshake. One held entry is granted
// per cycle. Entries with different addresses are granted round-robin. When
// both entries target the same register, the older entry is granted first so
// that writes reach that register in program order.
//
// Ports
//   clk, reset         rising-edge clock, synchronous active-high reset
//   flush              drops held entries, in-flight writes and this cycle's requests
//   req0_* / req1_*    valid/addr/data in, ready out, one set per source
//   mux_select         writeback mux select (0 = source 0, 1 = source 1)
//   wr_en/addr/data    registered register-file write port
module wb_port_arbiter #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,

  input  logic              req0_valid,
  input  logic [ADDR_W-1:0] req0_addr,
  input  logic [DATA_W-1:0] req0_data,
  output logic              req0_ready,

  input  logic              req1_valid,
  input  logic [ADDR_W-1:0] req1_addr,
  input  logic [DATA_W-1:0] req1_data,
  output logic              req1_ready,

  output logic              mux_select,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [DATA_W-1:0] wr_data
);

  // Holding entries
  logic              full0, full1;
  logic [ADDR_W-1:0] addr0, addr1;
  logic [DATA_W-1:0] data0, data1;

  // Index of the older entry when both are full; index of the last grant
  logic              older;
  logic              rr_last;

  logic              grant0, grant1, grant_any;
  logic              accept0, accept1;

  // Grant is decided from registered state only, so ready never depends
  // on valid in the same cycle.
  always_comb begin
    grant0 = 1'b0;
    grant1 = 1'b0;
    if (full0 && full1) begin
      if (addr0 == addr1) begin
        if (older) grant1 = 1'b1;
        else       grant0 = 1'b1;
      end else begin
        if (rr_last) grant0 = 1'b1;
        else         grant1 = 1'b1;
      end
    end else if (full0) begin
      grant0 = 1'b1;
    end else if (full1) begin
      grant1 = 1'b1;
    end
  end

  assign grant_any  = grant0 | grant1;

  // A draining entry can be refilled on the same edge.
  assign req0_ready = !full0 || grant0;
  assign req1_ready = !full1 || grant1;

  assign accept0    = req0_valid && req0_ready;
  assign accept1    = req1_valid && req1_ready;

  // Holding entries and age tracking
  always_ff @(posedge clk) begin
    if (reset) begin
      full0 <= 1'b0;
      full1 <= 1'b0;
      addr0 <= '0;
      addr1 <= '0;
      data0 <= '0;
      data1 <= '0;
      older <= 1'b0;
    end else if (flush) begin
      full0 <= 1'b0;
      full1 <= 1'b0;
    end else begin
      if (accept0) begin
        full0 <= 1'b1;
        addr0 <= req0_addr;
        data0 <= req0_data;
      end else if (grant0) begin
        full0 <= 1'b0;
      end

      if (accept1) begin
        full1 <= 1'b1;
        addr1 <= req1_addr;
        data1 <= req1_data;
      end else if (grant1) begin
        full1 <= 1'b0;
      end

      // A newly captured entry is younger than a partner that stays held.
      // Simultaneous captures make entry 0 the older one.
      if (accept0 && accept1) begin
        older <= 1'b0;
      end else if (accept0 && full1 && !grant1) begin
        older <= 1'b1;
      end else if (accept1 && full0 && !grant0) begin
        older <= 1'b0;
      end
    end
  end

  // Registered write port and round-robin pointer
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_en      <= 1'b0;
      wr_addr    <= '0;
      wr_data    <= '0;
      mux_select <= 1'b0;
      rr_last    <= 1'b1;
    end else if (flush) begin
      wr_en <= 1'b0;
    end else begin
      wr_en <= grant_any;
      if (grant_any) begin
        wr_addr    <= grant1 ? addr1 : addr0;
        wr_data    <= grant1 ? data1 : data0;
        mux_select <= grant1;
        rr_last    <= grant1;
      end
    end
  end

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Self-checking bench for wb_port_arbiter. Expected writes are queued as
// stimulus is applied; a negedge monitor pops and compares every wr_en pulse.
module tb_wb_port_arbiter;

  localparam int DW = 32;
  localparam int AW = 4;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          flush = 1'b0;
  logic          req0_valid = 1'b0, req1_valid = 1'b0;
  logic [AW-1:0] req0_addr = '0, req1_addr = '0;
  logic [DW-1:0] req0_data = '0, req1_data = '0;
  logic          req0_ready, req1_ready;
  logic          mux_select, wr_en;
  logic [AW-1:0] wr_addr;
  logic [DW-1:0] wr_data;

  wb_port_arbiter #(.DATA_W(DW), .ADDR_W(AW)) dut (
    .clk        (clk),
    .reset      (reset),
    .flush      (flush),
    .req0_valid (req0_valid),
    .req0_addr  (req0_addr),
    .req0_data  (req0_data),
    .req0_ready (req0_ready),
    .req1_valid (req1_valid),
    .req1_addr  (req1_addr),
    .req1_data  (req1_data),
    .req1_ready (req1_ready),
    .mux_select (mux_select),
    .wr_en      (wr_en),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
    logic          sel;
  } wr_t;

  wr_t           sb[$];
  wr_t           mon_e;
  logic [DW-1:0] rf [16];
  int            n_checks = 0;
  int            n_fail = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set0(input logic v, input logic [AW-1:0] a, input logic [DW-1:0] d);
    req0_valid = v;
    req0_addr  = a;
    req0_data  = d;
  endtask

  task automatic set1(input logic v, input logic [AW-1:0] a, input logic [DW-1:0] d);
    req1_valid = v;
    req1_addr  = a;
    req1_data  = d;
  endtask

  task automatic push(input logic [AW-1:0] a, input logic [DW-1:0] d, input logic s);
    wr_t e;
    e.addr = a;
    e.data = d;
    e.sel  = s;
    sb.push_back(e);
  endtask

  task automatic drain(input string tag);
    for (int i = 0; i < 20 && sb.size() != 0; i++) tick();
    repeat (2) tick();
    check(tag, 64'(sb.size()), 64'd0);
  endtask

  // Write monitor: every pulse must match the head of the scoreboard
  always @(negedge clk) begin
    if (wr_en === 1'b1) begin
      check("wr_expected", 64'(sb.size() > 0), 64'd1);
      if (sb.size() > 0) begin
        mon_e = sb.pop_front();
        check("wr_addr", 64'(wr_addr), 64'(mon_e.addr));
        check("wr_data", 64'(wr_data), 64'(mon_e.data));
        check("mux_select", 64'(mux_select), 64'(mon_e.sel));
      end
      rf[wr_addr] = wr_data;
    end
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish in time");
    $fatal(1, "timeout");
  end

  initial begin
    int  i0, i1;
    logic a0, a1;

    for (int i = 0; i < 16; i++) rf[i] = '0;

    repeat (3) @(posedge clk);
    #1 reset = 1'b0;

    // Idle after reset
    tick();
    check("idle_wr_en", 64'(wr_en), 64'd0);
    check("idle_rdy0", 64'(req0_ready), 64'd1);
    check("idle_rdy1", 64'(req1_ready), 64'd1);
    check("idle_mux", 64'(mux_select), 64'd0);
    check("idle_wr_addr", 64'(wr_addr), 64'd0);

    // Single request latency
    set0(1'b1, 4'd3, 32'hDEADBEEF);
    check("single_rdy0", 64'(req0_ready), 64'd1);
    push(4'd3, 32'hDEADBEEF, 1'b0);
    tick();
    set0(1'b0, '0, '0);
    check("single_lat_n", 64'(wr_en), 64'd0);
    tick();
    check("single_wr_en", 64'(wr_en), 64'd1);
    check("single_wr_data", 64'(wr_data), 64'hDEADBEEF);
    tick();
    check("single_wr_done", 64'(wr_en), 64'd0);
    drain("single_drain");

    // Reset again so round-robin starts from its reset pointer
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;

    // Continuous contention, different addresses: 0,1,0,1,...
    for (int k = 0; k < 4; k++) begin
      push(4'd1, 32'hA000_0000 + 32'(k), 1'b0);
      push(4'd2, 32'hB000_0000 + 32'(k), 1'b1);
    end
    i0 = 0;
    i1 = 0;
    for (int cyc = 0; cyc < 40 && (i0 < 4 || i1 < 4); cyc++) begin
      set0(i0 < 4, 4'd1, 32'hA000_0000 + 32'(i0));
      set1(i1 < 4, 4'd2, 32'hB000_0000 + 32'(i1));
      if (i0 > 0 && i0 < 4 && i1 < 4)
        check("rr_ready_alt", 64'(req0_ready ^ req1_ready), 64'd1);
      a0 = req0_valid && req0_ready;
      a1 = req1_valid && req1_ready;
      tick();
      if (a0) i0++;
      if (a1) i1++;
    end
    set0(1'b0, '0, '0);
    set1(1'b0, '0, '0);
    check("rr_accepted", 64'(i0 + i1), 64'd8);
    drain("rr_drain");

    // Same register, source 1 older (round-robin pointer is 1 here)
    set0(1'b1, 4'd9, 32'h99);
    set1(1'b1, 4'd5, 32'h11);
    push(4'd9, 32'h99, 1'b0);
    push(4'd5, 32'h11, 1'b1);
    push(4'd5, 32'h22, 1'b0);
    tick();
    set1(1'b0, '0, '0);
    set0(1'b1, 4'd5, 32'h22);
    check("age1_rdy0", 64'(req0_ready), 64'd1);
    check("age1_rdy1", 64'(req1_ready), 64'd0);
    tick();
    set0(1'b0, '0, '0);
    drain("age1_drain");
    check("age1_rf5", 64'(rf[5]), 64'h22);

    // Same register, captured on the same edge: source 0 goes first
    set0(1'b1, 4'd5, 32'h22);
    set1(1'b1, 4'd5, 32'h11);
    push(4'd5, 32'h22, 1'b0);
    push(4'd5, 32'h11, 1'b1);
    tick();
    set0(1'b0, '0, '0);
    set1(1'b0, '0, '0);
    drain("age0_drain");
    check("age0_rf5", 64'(rf[5]), 64'h11);

    // Flush with both entries full; request in the flush cycle is dropped
    set0(1'b1, 4'd1, 32'hF0);
    set1(1'b1, 4'd2, 32'hF1);
    tick();
    set0(1'b0, '0, '0);
    set1(1'b1, 4'd7, 32'h77);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    set1(1'b0, '0, '0);
    check("flush_wr_en", 64'(wr_en), 64'd0);
    check("flush_rdy0", 64'(req0_ready), 64'd1);
    check("flush_rdy1", 64'(req1_ready), 64'd1);
    tick();
    check("flush_no_wr", 64'(wr_en), 64'd0);
    set1(1'b1, 4'd6, 32'h66);
    push(4'd6, 32'h66, 1'b1);
    tick();
    set1(1'b0, '0, '0);
    drain("flush_drain");
    check("flush_rf7", 64'(rf[7]), 64'd0);

    // Reset while a write is due
    set0(1'b1, 4'd4, 32'h44);
    tick();
    set0(1'b0, '0, '0);
    reset = 1'b1;
    tick();
    check("rst_wr_en", 64'(wr_en), 64'd0);
    check("rst_mux", 64'(mux_select), 64'd0);
    check("rst_wr_data", 64'(wr_data), 64'd0);
    check("rst_rdy0", 64'(req0_ready), 64'd1);
    reset = 1'b0;
    repeat (3) tick();
    check("rst_no_wr", 64'(wr_en), 64'd0);
    check("rst_rf4", 64'(rf[4]), 64'd0);

    check("sb_empty", 64'(sb.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
